fpu_issue_ctrl: RTL and testbench

Execution-side counterpart of the RV32F instruction decoder. It consumes the decoded `fpu_en`/`fpu_op` pair and the operands. It then:
- stalls the single-cycle core;
- issues a start/done handshake to a multi-cycle FP arithmetic datapath;
- writes the result back to the FP register file.

It sits between the decode stage and the FP datapath and register file. It also flags unsupported FP ops and datapath timeouts.

---
 rtl/fpu_issue_ctrl_if.sv | 33 +++
 rtl/fpu_issue_ctrl.sv | 97 +++++++++
 tb/tb_fpu_issue_ctrl.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/fpu_issue_ctrl_if.sv
// Handshake bundle between decode, the FP issue controller, the FP datapath and the FP register file.
// The master side is the decode/datapath environment; the slave side is the controller.
interface fpu_issue_ctrl_if #(
  parameter int XLEN = 32
);
  logic            fpu_en;
  logic [4:0]      fpu_op;
  logic [4:0]      rd;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  logic            stall;
  logic            illegal;
  logic            ex_start;
  logic [1:0]      ex_op;
  logic [XLEN-1:0] ex_a;
  logic [XLEN-1:0] ex_b;
  logic            ex_done;
  logic [XLEN-1:0] ex_result;
  logic            wb_en;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            timeout;

  modport master (
    output fpu_en, fpu_op, rd, rs1_val, rs2_val, ex_done, ex_result,
    input  stall, illegal, ex_start, ex_op, ex_a, ex_b, wb_en, wb_rd, wb_data, timeout
  );

  modport slave (
    input  fpu_en, fpu_op, rd, rs1_val, rs2_val, ex_done, ex_result,
    output stall, illegal, ex_start, ex_op, ex_a, ex_b, wb_en, wb_rd, wb_data, timeout
  );
endinterface

// File: rtl/fpu_issue_ctrl.sv
// FP issue controller: stalls the core, runs a start/done handshake with the FP datapath
// and writes the result (or a quiet NaN after a timeout) back to the FP register file.
module fpu_issue_ctrl #(
  parameter int                 XLEN    = 32,
  parameter int                 TIMEOUT = 64,
  parameter logic [XLEN-1:0]    NAN_VAL = 32'h7FC00000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  fpu_issue_ctrl_if.slave       bus
);

  localparam int             CW      = $clog2(TIMEOUT);
  localparam logic [CW-1:0]  TO_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, WB} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt;
  logic [4:0]      rd_q;
  logic            accept;
  logic            fin_done;
  logic            fin_to;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    accept      = 1'b0;
    fin_done    = 1'b0;
    fin_to      = 1'b0;
    bus.illegal = 1'b0;
    case (state)
      IDLE: begin
        if (bus.fpu_en) begin
          if (bus.fpu_op <= 5'd3) begin
            accept    = 1'b1;
            state_nxt = ISSUE;
          end else begin
            bus.illegal = 1'b1;
          end
        end
      end
      ISSUE: state_nxt = WAIT;
      WAIT: begin
        // a done arriving on the last allowed cycle still beats the timeout
        if (bus.ex_done) begin
          fin_done  = 1'b1;
          state_nxt = WB;
        end else if (cnt == TO_LAST) begin
          fin_to    = 1'b1;
          state_nxt = WB;
        end
      end
      WB:      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    bus.stall = accept | (state == ISSUE) | (state == WAIT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt          <= '0;
      rd_q         <= '0;
      bus.ex_start <= 1'b0;
      bus.ex_op    <= '0;
      bus.ex_a     <= '0;
      bus.ex_b     <= '0;
      bus.wb_en    <= 1'b0;
      bus.wb_rd    <= '0;
      bus.wb_data  <= '0;
      bus.timeout  <= 1'b0;
    end else begin
      bus.ex_start <= accept;
      if (accept) begin
        bus.ex_a  <= bus.rs1_val;
        bus.ex_b  <= bus.rs2_val;
        bus.ex_op <= bus.fpu_op[1:0];
        rd_q      <= bus.rd;
      end

      if (state == ISSUE)     cnt <= '0;
      else if (state == WAIT) cnt <= cnt + 1'b1;

      bus.wb_en   <= (fin_done | fin_to) & (rd_q != 5'd0);
      bus.timeout <= fin_to;
      if (fin_done | fin_to) begin
        bus.wb_rd   <= rd_q;
        bus.wb_data <= fin_done ? bus.ex_result : NAN_VAL;
      end
    end
  end

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Randomized bench for fpu_issue_ctrl, checked against a per-operation timeline model.
module tb_fpu_issue_ctrl;

  localparam int          TIMEOUT = 64;
  localparam logic [31:0] NAN_VAL = 32'h7FC00000;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;

  fpu_issue_ctrl_if #(.XLEN(32)) bus ();

  fpu_issue_ctrl #(
    .XLEN    (32),
    .TIMEOUT (TIMEOUT),
    .NAN_VAL (NAN_VAL)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic drive_noise();
    bus.fpu_en  = 1'($urandom_range(0, 1));
    bus.fpu_op  = 5'($urandom);
    bus.rd      = 5'($urandom);
    bus.rs1_val = $urandom;
    bus.rs2_val = $urandom;
  endtask

  // Timeline model of one accepted op, cycle 0 = accept cycle.
  // lat = cycles from ex_start to ex_done (0 = datapath never answers).
  // The datapath answers in time when lat <= TIMEOUT; WB then lands at cycle lat+2,
  // otherwise the op times out with WB at cycle TIMEOUT+2.
  task automatic run_op(input logic [4:0] op, input logic [4:0] rd, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] res, input int lat,
                        input int abort_at);
    bit to;
    int wbc;
    to  = (lat <= 0) || (lat > TIMEOUT);
    wbc = to ? TIMEOUT + 2 : lat + 2;
    for (int c = 0; c <= wbc; c++) begin
      @(negedge clk);
      if (c == 0) begin
        bus.fpu_en    = 1'b1;
        bus.fpu_op    = op;
        bus.rd        = rd;
        bus.rs1_val   = a;
        bus.rs2_val   = b;
        bus.ex_done   = 1'b0;
        bus.ex_result = $urandom;
      end else begin
        drive_noise();
        if (c == 1 || c == wbc) bus.ex_done = 1'($urandom_range(0, 1));
        else                    bus.ex_done = (!to && c == lat + 1);
        bus.ex_result = (!to && c == lat + 1) ? res : $urandom;
      end
      #1;
      chk("stall",    32'(bus.stall),    32'(c < wbc));
      chk("illegal",  32'(bus.illegal),  32'd0);
      chk("ex_start", 32'(bus.ex_start), 32'(c == 1));
      chk("wb_en",    32'(bus.wb_en),    32'(c == wbc && rd != 5'd0));
      chk("timeout",  32'(bus.timeout),  32'(c == wbc && to));
      if (c >= 1) begin
        chk("ex_a",  bus.ex_a, a);
        chk("ex_b",  bus.ex_b, b);
        chk("ex_op", 32'(bus.ex_op), 32'(op[1:0]));
      end
      if (c == wbc) begin
        chk("wb_rd",   32'(bus.wb_rd), 32'(rd));
        chk("wb_data", bus.wb_data, to ? NAN_VAL : res);
      end
      if (c == abort_at) begin
        rst_n = 1'b0;
        #1;
        chk("rst_stall",    32'(bus.stall),    32'd0);
        chk("rst_ex_start", 32'(bus.ex_start), 32'd0);
        chk("rst_wb_en",    32'(bus.wb_en),    32'd0);
        chk("rst_ex_a",     bus.ex_a,          32'd0);
        return;
      end
    end
  endtask

  task automatic illegal_op(input logic [4:0] op);
    @(negedge clk);
    bus.fpu_en  = 1'b1;
    bus.fpu_op  = op;
    bus.rd      = 5'($urandom);
    bus.ex_done = 1'($urandom_range(0, 1));
    #1;
    chk("ill_illegal", 32'(bus.illegal), 32'd1);
    chk("ill_stall",   32'(bus.stall),   32'd0);
    @(negedge clk);
    bus.fpu_en  = 1'b0;
    bus.ex_done = 1'b0;
    #1;
    chk("ill_ex_start", 32'(bus.ex_start), 32'd0);
    chk("ill_wb_en",    32'(bus.wb_en),    32'd0);
    chk("ill_after",    32'(bus.illegal),  32'd0);
    chk("ill_stall2",   32'(bus.stall),    32'd0);
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    drive_noise();
    bus.fpu_en  = 1'b0;
    bus.ex_done = 1'($urandom_range(0, 1));
    #1;
    chk("idle_stall",    32'(bus.stall),    32'd0);
    chk("idle_illegal",  32'(bus.illegal),  32'd0);
    chk("idle_ex_start", 32'(bus.ex_start), 32'd0);
    chk("idle_wb_en",    32'(bus.wb_en),    32'd0);
    chk("idle_timeout",  32'(bus.timeout),  32'd0);
  endtask

  initial begin
    int kind;
    int lat;
    n_checks      = 0;
    n_pass        = 0;
    rst_n         = 1'b0;
    bus.fpu_en    = 1'b0;
    bus.fpu_op    = '0;
    bus.rd        = '0;
    bus.rs1_val   = '0;
    bus.rs2_val   = '0;
    bus.ex_done   = 1'b0;
    bus.ex_result = '0;

    #12;
    chk("reset_stall",    32'(bus.stall),    32'd0);
    chk("reset_illegal",  32'(bus.illegal),  32'd0);
    chk("reset_ex_start", 32'(bus.ex_start), 32'd0);
    chk("reset_wb_en",    32'(bus.wb_en),    32'd0);
    chk("reset_wb_data",  bus.wb_data,       32'd0);
    chk("reset_timeout",  32'(bus.timeout),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle_cycle();

    run_op(5'd0, 5'd5, 32'h3F800000, 32'h40000000, 32'h40400000, 2, -1);
    illegal_op(5'd31);
    illegal_op(5'd4);
    run_op(5'd3, 5'd7, $urandom, $urandom, $urandom, 0, -1);
    run_op(5'd2, 5'd0, $urandom, $urandom, $urandom, 3, -1);

    // reset in the middle of WAIT, then a late done that must not write back
    run_op(5'd2, 5'd9, $urandom, $urandom, 32'h12345678, 5, 4);
    @(negedge clk);
    rst_n       = 1'b1;
    bus.fpu_en  = 1'b0;
    bus.ex_done = 1'b1;
    #1;
    chk("late_stall", 32'(bus.stall), 32'd0);
    @(negedge clk);
    bus.ex_done = 1'b0;
    #1;
    chk("late_wb_en",   32'(bus.wb_en),   32'd0);
    chk("late_timeout", 32'(bus.timeout), 32'd0);
    run_op(5'd1, 5'd6, $urandom, $urandom, $urandom, 1, -1);

    // back-to-back: second accept in the cycle after the first WB
    run_op(5'd0, 5'd3, $urandom, $urandom, 32'hAAAA0003, 1, -1);
    run_op(5'd1, 5'd4, $urandom, $urandom, 32'hBBBB0004, 2, -1);

    // done coinciding with the timeout, and one cycle too late
    run_op(5'd3, 5'd8, $urandom, $urandom, 32'hC0FFEE00, TIMEOUT, -1);
    run_op(5'd3, 5'd8, $urandom, $urandom, 32'hC0FFEE01, TIMEOUT + 1, -1);

    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 9);
      if (kind == 0) idle_cycle();
      else if (kind == 1) illegal_op(5'($urandom_range(4, 31)));
      else begin
        lat = (kind == 2) ? $urandom_range(TIMEOUT - 1, TIMEOUT + 1) : $urandom_range(1, 8);
        if (kind == 3 && $urandom_range(0, 3) == 0) lat = 0;
        run_op(5'($urandom_range(0, 3)), 5'($urandom), $urandom, $urandom, $urandom, lat, -1);
      end
    end
    idle_cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
